// File: rtl/mask_pack.sv
// -----------------------------------------------------------------------------
// mask_pack
//   Packs a stream of DW-bit lane values into NB-lane words. Lane placement is
//   dictated by a one-hot mask from an external mask generator, which this
//   block advances through shift_enable. A word goes to the output register
//   when the last lane is written, or as a partial word on flush. After a
//   partial word, the generator is walked back to lane 0 (REALIGN) before new
//   data is taken.
//
// Ports
//   clk          system clock, all state on the rising edge
//   n_rst        asynchronous active-low reset
//   in_data      lane data
//   in_valid     in_data valid
//   in_ready     lane value accepted at the edge where in_valid && in_ready
//   flush        single-cycle request to emit the partially assembled word
//   mask         one-hot lane select from the mask generator (bit 0 = lane 0)
//   shift_enable advances the mask generator by one lane
//   out_data     assembled word, lane i at [i*DW +: DW]
//   out_strobe   lanes of out_data holding valid data
//   out_valid    out_data/out_strobe valid
//   out_ready    word consumed at the edge where out_valid && out_ready
//   mask_err     sticky flag: mask was seen not exactly one-hot
// -----------------------------------------------------------------------------
module mask_pack #(
  parameter int NB = 8,
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [NB-1:0]    mask,
  output logic             shift_enable,
  output logic [NB*DW-1:0] out_data,
  output logic [NB-1:0]    out_strobe,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             mask_err
);

  typedef enum logic {
    FILL    = 1'b0,
    REALIGN = 1'b1
  } state_e;

  state_e             state_q,      state_d;
  logic [NB*DW-1:0]   asm_data_q,   asm_data_d;
  logic [NB-1:0]      asm_flags_q,  asm_flags_d;
  logic               pending_q,    pending_d;
  logic [NB*DW-1:0]   out_data_q,   out_data_d;
  logic [NB-1:0]      out_strobe_q, out_strobe_d;
  logic               out_valid_q,  out_valid_d;
  logic               mask_err_q,   mask_err_d;

  logic out_free;
  logic accept;

  // The output register can take a new word if it is empty or being drained
  // at this same edge.
  assign out_free = !out_valid_q || out_ready;

  // Handshake outputs are also gated by n_rst so they read 0 throughout reset,
  // independent of what the mask input is doing.
  assign in_ready = n_rst && (state_q == FILL) && !pending_q && !mask_err_q &&
                    !(mask[NB-1] && !out_free);

  assign accept = in_valid && in_ready;

  assign shift_enable = n_rst && !mask_err_q &&
                        (((state_q == FILL) && accept) ||
                         ((state_q == REALIGN) && !mask[0]));

  // NOTE: every signal written here gets its default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    asm_data_d   = asm_data_q;
    asm_flags_d  = asm_flags_q;
    pending_d    = pending_q;
    out_data_d   = out_data_q;
    out_strobe_d = out_strobe_q;
    out_valid_d  = out_valid_q;
    mask_err_d   = mask_err_q | !$onehot(mask);

    if (accept) begin
      for (int i = 0; i < NB; i++) begin
        if (mask[i]) asm_data_d[i*DW +: DW] = in_data;
      end
      asm_flags_d = asm_flags_q | mask;
    end

    if (accept && mask[NB-1]) begin
      // Last lane written: the merged word moves out whole.
      out_data_d   = asm_data_d;
      out_strobe_d = '1;
      out_valid_d  = 1'b1;
      asm_data_d   = '0;
      asm_flags_d  = '0;
    end else if (pending_q && out_free) begin
      // Partial word: unwritten lanes are already 0 because the assembly
      // register is cleared on every transfer.
      out_data_d   = asm_data_q;
      out_strobe_d = asm_flags_q;
      out_valid_d  = 1'b1;
      asm_data_d   = '0;
      asm_flags_d  = '0;
      pending_d    = 1'b0;
      state_d      = REALIGN;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Evaluated after the same-cycle accept so that byte joins the partial;
    // a flush that leaves nothing written (including one on the last lane) is
    // dropped.
    if (flush && (|asm_flags_d)) pending_d = 1'b1;

    if ((state_q == REALIGN) && mask[0]) state_d = FILL;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the assembly register is reset along with the control state so a
  // word interrupted by reset can never leak into the next one.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= FILL;
      asm_data_q   <= '0;
      asm_flags_q  <= '0;
      pending_q    <= 1'b0;
      out_data_q   <= '0;
      out_strobe_q <= '0;
      out_valid_q  <= 1'b0;
      mask_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      asm_data_q   <= asm_data_d;
      asm_flags_q  <= asm_flags_d;
      pending_q    <= pending_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
      out_valid_q  <= out_valid_d;
      mask_err_q   <= mask_err_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_strobe = out_strobe_q;
  assign out_valid  = out_valid_q;
  assign mask_err   = mask_err_q;

endmodule
